// File: rtl/rhs_pkg.sv
// -----------------------------------------------------------------------------
// rhs_pkg
// Shared types and constants for the RHS frame packer.
//   RHS_NUM_CH    default number of channel words per sample frame
//   RHS_MAGIC     64-bit frame header; the low word goes out first
//   pk_state_t    output framing FSM states
//   fifo_word_t   FIFO entry: channel word plus end-of-packet marker
//   eff_batch_len frames-per-packet with 0 promoted to 1
// -----------------------------------------------------------------------------
package rhs_pkg;

  localparam int          RHS_NUM_CH = 32;
  localparam logic [63:0] RHS_MAGIC  = 64'hD7A2_2AAA_3813_2A53;

  typedef enum logic [1:0] {
    IDLE,
    HDR0,
    HDR1,
    DATA
  } pk_state_t;

  typedef struct packed {
    logic        last;
    logic [31:0] data;
  } fifo_word_t;

  function automatic logic [7:0] eff_batch_len(input logic [7:0] len);
    return (len == 8'd0) ? 8'd1 : len;
  endfunction

endpackage

// File: rtl/rhs_frame_packer_if.sv
// -----------------------------------------------------------------------------
// rhs_frame_packer_if
// Bundles the sample-word input (from the SPI/stim controller) and the
// AXI4-Stream output of the frame packer.
//   s_valid/s_sof/s_data                      channel words, no backpressure
//   m_axis_tdata/tvalid/tready/tlast          framed packet stream
// Modports:
//   master  the packer side (consumes samples, drives the stream)
//   slave   the environment side (drives samples, sinks the stream)
// -----------------------------------------------------------------------------
interface rhs_frame_packer_if;

  logic        s_valid;
  logic        s_sof;
  logic [31:0] s_data;

  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        m_axis_tlast;

  modport master (
    input  s_valid, s_sof, s_data, m_axis_tready,
    output m_axis_tdata, m_axis_tvalid, m_axis_tlast
  );

  modport slave (
    output s_valid, s_sof, s_data, m_axis_tready,
    input  m_axis_tdata, m_axis_tvalid, m_axis_tlast
  );

endinterface

// File: rtl/rhs_sync_fifo.sv
// -----------------------------------------------------------------------------
// rhs_sync_fifo
// Single-clock first-word-fall-through FIFO of fifo_word_t entries.
//   clk, rst     clock and synchronous active-high reset (flushes the FIFO)
//   push_i       write wr_data_i this cycle
//   pop_i        consume the head entry this cycle
//   rd_data_o    head entry, valid whenever empty_o is low
//   count_o      number of stored entries (0..DEPTH)
//   empty_o      no entries stored
// The user guarantees no push when full and no pop when empty; push and pop
// in the same cycle are both applied to the count.
// -----------------------------------------------------------------------------
module rhs_sync_fifo
  import rhs_pkg::*;
#(
  parameter int DEPTH = 128
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  fifo_word_t               wr_data_i,
  input  logic                     pop_i,
  output fifo_word_t               rd_data_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fifo_word_t    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;

  // NOTE: sequential state is always assigned with <= so every flop samples
  // the pre-edge value of every other flop, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_i)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + CW'(push_i) - CW'(pop_i);
    end
  end

  // NOTE: the storage array is deliberately left out of reset; the pointers
  // and count define which entries are meaningful, and a resettable array
  // would prevent mapping onto RAM.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= wr_data_i;
  end

  assign rd_data_o = mem_q[rd_ptr_q];
  assign count_o   = count_q;
  assign empty_o   = (count_q == '0);

endmodule

// File: rtl/rhs_frame_packer.sv
// -----------------------------------------------------------------------------
// rhs_frame_packer
// Buffers per-sample channel words and frames them into AXI4-Stream packets:
// each frame is MAGIC[31:0], MAGIC[63:32], then NUM_CH channel words; a
// packet is batch_len frames with tlast on its final word.
//   aclk, areset    clock, synchronous active-high reset
//   enable          allows a new packet to open at the next frame start
//   batch_len       frames per packet, latched when a packet opens (0 -> 1)
//   clr_status      pulse clearing overflow, frame_err and frames_dropped
//   bus             sample input and AXI4-Stream output (master modport)
//   overflow        sticky: a frame was dropped for lack of FIFO space
//   frame_err       sticky: s_sof seen in the middle of a frame
//   frames_dropped  saturating dropped-frame count
//   busy            packet open, FIFO not empty, or output FSM active
// -----------------------------------------------------------------------------
module rhs_frame_packer
  import rhs_pkg::*;
#(
  parameter int          NUM_CH     = RHS_NUM_CH,
  parameter int          FIFO_DEPTH = 128,
  parameter logic [63:0] MAGIC      = RHS_MAGIC
) (
  input  logic                aclk,
  input  logic                areset,
  input  logic                enable,
  input  logic [7:0]          batch_len,
  input  logic                clr_status,
  rhs_frame_packer_if.master  bus,
  output logic                overflow,
  output logic                frame_err,
  output logic [15:0]         frames_dropped,
  output logic                busy
);

  localparam int              CW          = $clog2(FIFO_DEPTH) + 1;
  localparam int              WW          = $clog2(NUM_CH);
  localparam logic [WW-1:0]   LAST_WORD   = WW'(NUM_CH - 1);
  localparam logic [CW-1:0]   FRAME_WORDS = CW'(NUM_CH);
  localparam logic [CW-1:0]   DEPTH_W     = CW'(FIFO_DEPTH);

  // ---------------------------------------------------------------- FIFO
  logic          fifo_push;
  logic          fifo_pop;
  fifo_word_t    fifo_wr;
  fifo_word_t    fifo_rd;
  logic [CW-1:0] fifo_count;
  logic          fifo_empty;
  logic [CW-1:0] fifo_free;
  logic          frame_ready;

  rhs_sync_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (aclk),
    .rst       (areset),
    .push_i    (fifo_push),
    .wr_data_i (fifo_wr),
    .pop_i     (fifo_pop),
    .rd_data_o (fifo_rd),
    .count_o   (fifo_count),
    .empty_o   (fifo_empty)
  );

  assign fifo_free   = DEPTH_W - fifo_count;
  // A whole frame must be buffered before its header goes out, so the data
  // words behind the header never stall on an empty FIFO.
  assign frame_ready = (fifo_count >= FRAME_WORDS);

  // ---------------------------------------------------------- input side
  logic [WW-1:0] in_word_cnt_q,  in_word_cnt_d;
  logic [7:0]    in_frame_cnt_q, in_frame_cnt_d;
  logic          pkt_open_q,     pkt_open_d;
  logic [7:0]    pkt_len_q,      pkt_len_d;
  logic          keep_q,         keep_d;   // current frame is being stored
  logic          overflow_q;
  logic          frame_err_q;
  logic [15:0]   dropped_q;
  logic          drop_evt;
  logic          mid_sof;
  logic          push_last;

  assign mid_sof   = bus.s_valid && bus.s_sof && (in_word_cnt_q != '0);
  assign push_last = (in_word_cnt_q == LAST_WORD) &&
                     (in_frame_cnt_q == pkt_len_q - 8'd1);
  assign fifo_wr   = '{last: push_last, data: bus.s_data};

  // NOTE: every signal driven here gets a default first, so no path leaves a
  // value unassigned and no latch is inferred.
  always_comb begin
    in_word_cnt_d  = in_word_cnt_q;
    in_frame_cnt_d = in_frame_cnt_q;
    pkt_open_d     = pkt_open_q;
    pkt_len_d      = pkt_len_q;
    keep_d         = keep_q;
    fifo_push      = 1'b0;
    drop_evt       = 1'b0;

    if (bus.s_valid) begin
      if (in_word_cnt_q == '0) begin
        // Between frames only a frame start is meaningful; stray words drop.
        if (bus.s_sof) begin
          in_word_cnt_d = WW'(1);
          keep_d        = 1'b0;
          if (pkt_open_q || enable) begin
            if (!pkt_open_q) begin
              pkt_open_d = 1'b1;
              pkt_len_d  = eff_batch_len(batch_len);
            end
            // Space for the whole frame is reserved up front, so once a frame
            // is accepted none of its words can be lost.
            if (fifo_free < FRAME_WORDS) begin
              drop_evt = 1'b1;
            end else begin
              keep_d    = 1'b1;
              fifo_push = 1'b1;
            end
          end
        end
      end else begin
        // A mid-frame s_sof is flagged elsewhere and otherwise treated as data.
        fifo_push     = keep_q;
        in_word_cnt_d = (in_word_cnt_q == LAST_WORD) ? '0 : in_word_cnt_q + WW'(1);
        if (keep_q && (in_word_cnt_q == LAST_WORD)) begin
          if (push_last) begin
            pkt_open_d     = 1'b0;
            in_frame_cnt_d = '0;
          end else begin
            in_frame_cnt_d = in_frame_cnt_q + 8'd1;
          end
        end
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      in_word_cnt_q  <= '0;
      in_frame_cnt_q <= '0;
      pkt_open_q     <= 1'b0;
      pkt_len_q      <= 8'd1;
      keep_q         <= 1'b0;
      overflow_q     <= 1'b0;
      frame_err_q    <= 1'b0;
      dropped_q      <= '0;
    end else begin
      in_word_cnt_q  <= in_word_cnt_d;
      in_frame_cnt_q <= in_frame_cnt_d;
      pkt_open_q     <= pkt_open_d;
      pkt_len_q      <= pkt_len_d;
      keep_q         <= keep_d;

      // A new event in the same cycle as clr_status takes precedence.
      if (drop_evt) begin
        overflow_q <= 1'b1;
        if (clr_status)                dropped_q <= 16'd1;
        else if (dropped_q != 16'hFFFF) dropped_q <= dropped_q + 16'd1;
      end else if (clr_status) begin
        overflow_q <= 1'b0;
        dropped_q  <= '0;
      end

      if (mid_sof)         frame_err_q <= 1'b1;
      else if (clr_status) frame_err_q <= 1'b0;
    end
  end

  // ---------------------------------------------------------- output side
  pk_state_t     state_q;
  logic [WW-1:0] data_cnt_q;   // index of the data word currently presented
  logic [31:0]   tdata_q;
  logic          tvalid_q;
  logic          tlast_q;
  logic          hs;

  assign hs = tvalid_q && bus.m_axis_tready;

  // The head word is moved into the output register on the handshake of the
  // previous beat: after HDR1, and after every data word except the last.
  assign fifo_pop = hs && ((state_q == HDR1) ||
                           ((state_q == DATA) && (data_cnt_q != LAST_WORD)));

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q    <= IDLE;
      data_cnt_q <= '0;
      tdata_q    <= '0;
      tvalid_q   <= 1'b0;
      tlast_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (frame_ready) begin
            state_q  <= HDR0;
            tvalid_q <= 1'b1;
            tdata_q  <= MAGIC[31:0];
            tlast_q  <= 1'b0;
          end
        end
        HDR0: begin
          if (hs) begin
            state_q <= HDR1;
            tdata_q <= MAGIC[63:32];
          end
        end
        HDR1: begin
          if (hs) begin
            state_q    <= DATA;
            data_cnt_q <= '0;
            tdata_q    <= fifo_rd.data;
            tlast_q    <= fifo_rd.last;
          end
        end
        DATA: begin
          if (hs) begin
            if (data_cnt_q != LAST_WORD) begin
              data_cnt_q <= data_cnt_q + WW'(1);
              tdata_q    <= fifo_rd.data;
              tlast_q    <= fifo_rd.last;
            end else if (!tlast_q && frame_ready) begin
              // Next frame of the same packet already buffered: no bubble.
              state_q <= HDR0;
              tdata_q <= MAGIC[31:0];
              tlast_q <= 1'b0;
            end else begin
              state_q  <= IDLE;
              tvalid_q <= 1'b0;
              tlast_q  <= 1'b0;
            end
          end
        end
        default: begin
          state_q  <= IDLE;
          tvalid_q <= 1'b0;
          tlast_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.m_axis_tdata  = tdata_q;
  assign bus.m_axis_tvalid = tvalid_q;
  assign bus.m_axis_tlast  = tlast_q;

  assign overflow       = overflow_q;
  assign frame_err      = frame_err_q;
  assign frames_dropped = dropped_q;
  assign busy           = pkt_open_q || !fifo_empty || (state_q != IDLE);

endmodule
